// File: rtl/pipe_pkg.sv
// pipe_pkg: lane-order constants, lane mapping and the OUT_W/IN_W ratio check shared by the pipe packers
`define PIPE_RATIO_CHECK(iw, ow) if (!((ow) == (iw) || (ow) == 2*(iw) || (ow) == 4*(iw) || (ow) == 8*(iw))) begin : g_bad_ratio $error("OUT_W must be 1, 2, 4 or 8 times IN_W"); end
package pipe_pkg;
  localparam bit LANE_LS_FIRST = 1'b0;
  localparam bit LANE_MS_FIRST = 1'b1;
  function automatic int lane_idx(input int lane, input bit msw_first, input int ratio);
    return (msw_first == LANE_MS_FIRST) ? ratio - 1 - lane : lane;
  endfunction
endpackage

// File: rtl/pipe_addr_gen.sv
// pipe_addr_gen: start/end address pointer with optional wrap, full flag and word counter (ptr_o, full_o, wcount_o advance on step_i)
module pipe_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              restart_i,
  input  logic [ADDR_W-1:0] saddr_i,
  input  logic [ADDR_W-1:0] eaddr_i,
  input  logic              wrap_en_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              full_o,
  output logic [ADDR_W:0]   wcount_o
);
  logic [ADDR_W-1:0] start_q, end_q;
  logic              wrap_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_o    <= '0;
      start_q  <= '0;
      end_q    <= '0;
      wrap_q   <= 1'b0;
      full_o   <= 1'b0;
      wcount_o <= '0;
    end else if (restart_i) begin
      ptr_o    <= saddr_i;
      start_q  <= saddr_i;
      end_q    <= eaddr_i;
      wrap_q   <= wrap_en_i;
      full_o   <= 1'b0;
      wcount_o <= '0;
    end else if (step_i) begin
      wcount_o <= wcount_o + 1'b1;
      if (ptr_o != end_q) ptr_o <= ptr_o + 1'b1;
      else if (wrap_q) ptr_o <= start_q;
      else full_o <= 1'b1;
    end
  end
endmodule

// File: rtl/pipe_pack.sv
// pipe_pack: packs OUT_W/IN_W pipe words (wea_i/data_i, flush_i) into RAM writes (wea_o/data_o/addr_o) with wcount_o, full_o, ovf_o status
module pipe_pack
  import pipe_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              restart_i,
  input  logic [ADDR_W-1:0] saddr_i,
  input  logic [ADDR_W-1:0] eaddr_i,
  input  logic              wrap_en_i,
  input  logic              msw_first_i,
  input  logic              wea_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic              flush_i,
  output logic [OUT_W-1:0]  data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wea_o,
  output logic [ADDR_W:0]   wcount_o,
  output logic              full_o,
  output logic              ovf_o
);
  localparam int RATIO = OUT_W / IN_W;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  `PIPE_RATIO_CHECK(IN_W, OUT_W)
  logic [LW-1:0]     lane_q;
  logic [OUT_W-1:0]  asm_q, asm_n;
  logic              msw_q, accept, emit;
  logic [ADDR_W-1:0] ptr;
  assign accept = wea_i & ~full_o;
  assign emit   = (accept & (lane_q == LW'(RATIO - 1))) | (flush_i & (accept | (lane_q != '0)));
  always_comb begin
    asm_n = asm_q;
    for (int l = 0; l < RATIO; l++)
      asm_n[l*IN_W +: IN_W] = (accept && lane_idx(int'(lane_q), msw_q, RATIO) == l) ? data_i : asm_q[l*IN_W +: IN_W];
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lane_q <= '0;
      asm_q  <= '0;
      msw_q  <= 1'b0;
      data_o <= '0;
      addr_o <= '0;
      wea_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (restart_i) begin
      lane_q <= '0;
      asm_q  <= '0;
      msw_q  <= msw_first_i;
      data_o <= '0;
      addr_o <= '0;
      wea_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      wea_o <= emit;
      if (wea_i && full_o) ovf_o <= 1'b1;
      if (emit) begin
        data_o <= asm_n;
        addr_o <= ptr;
        asm_q  <= '0;
        lane_q <= '0;
      end else if (accept) begin
        asm_q  <= asm_n;
        lane_q <= lane_q + 1'b1;
      end
    end
  end
  pipe_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .restart_i (restart_i),
    .saddr_i   (saddr_i),
    .eaddr_i   (eaddr_i),
    .wrap_en_i (wrap_en_i),
    .step_i    (emit),
    .ptr_o     (ptr),
    .full_o    (full_o),
    .wcount_o  (wcount_o)
  );
endmodule

// File: tb/tb_pipe_pack.sv
// tb_pipe_pack: directed vectors against a 16->32 and a 16->64 pipe_pack instance
module tb_pipe_pack;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        restart, wrap_en, msw_first, wea, flush;
  logic [15:0] saddr, eaddr, data;
  logic [31:0] data_o;
  logic [15:0] addr_o;
  logic        wea_o, full_o, ovf_o;
  logic [16:0] wcount_o;
  logic        restart2, wea2, flush2;
  logic [15:0] data2;
  logic [63:0] data_o2;
  logic [15:0] addr_o2;
  logic        wea_o2, full_o2, ovf_o2;
  logic [16:0] wcount_o2;
  int          n_vec = 0, n_err = 0;
  always #5 clk_i = ~clk_i;
  pipe_pack u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .restart_i(restart), .saddr_i(saddr), .eaddr_i(eaddr),
    .wrap_en_i(wrap_en), .msw_first_i(msw_first), .wea_i(wea), .data_i(data), .flush_i(flush),
    .data_o(data_o), .addr_o(addr_o), .wea_o(wea_o), .wcount_o(wcount_o), .full_o(full_o), .ovf_o(ovf_o)
  );
  pipe_pack #(.OUT_W(64)) u_dut64 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .restart_i(restart2), .saddr_i(16'h0000), .eaddr_i(16'h00FF),
    .wrap_en_i(1'b0), .msw_first_i(1'b0), .wea_i(wea2), .data_i(data2), .flush_i(flush2),
    .data_o(data_o2), .addr_o(addr_o2), .wea_o(wea_o2), .wcount_o(wcount_o2), .full_o(full_o2), .ovf_o(ovf_o2)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask
  task automatic rearm(input logic [15:0] s, input logic [15:0] e, input logic w, input logic m);
    saddr = s; eaddr = e; wrap_en = w; msw_first = m; restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask
  task automatic push(input logic [15:0] d);
    wea = 1'b1; data = d;
    cycle();
    wea = 1'b0;
  endtask
  task automatic push2(input logic [15:0] d);
    wea2 = 1'b1; data2 = d;
    cycle();
    wea2 = 1'b0;
  endtask
  initial begin
    restart = 0; wrap_en = 0; msw_first = 0; wea = 0; flush = 0; saddr = 0; eaddr = 0; data = 0;
    restart2 = 0; wea2 = 0; flush2 = 0; data2 = 0;
    cycle();
    cycle();
    check("rst wea_o", 64'(wea_o), 0);
    check("rst data_o", 64'(data_o), 0);
    check("rst addr_o", 64'(addr_o), 0);
    check("rst wcount_o", 64'(wcount_o), 0);
    check("rst full/ovf", {62'd0, full_o, ovf_o}, 0);
    rst_n_i = 1'b1;
    rearm(16'h0010, 16'h00FF, 1'b0, 1'b0);
    push(16'h1111);
    check("ls first word no write", 64'(wea_o), 0);
    push(16'h2222);
    check("ls wea_o", 64'(wea_o), 1);
    check("ls data_o", 64'(data_o), 64'h2222_1111);
    check("ls addr_o", 64'(addr_o), 64'h0010);
    check("ls wcount_o", 64'(wcount_o), 1);
    cycle();
    check("ls wea_o one cycle", 64'(wea_o), 0);
    check("ls data_o holds", 64'(data_o), 64'h2222_1111);
    rearm(16'h0010, 16'h00FF, 1'b0, 1'b1);
    check("restart clears wcount", 64'(wcount_o), 0);
    check("restart clears data_o", 64'(data_o), 0);
    push(16'hAAAA);
    push(16'hBBBB);
    check("ms wea_o", 64'(wea_o), 1);
    check("ms data_o", 64'(data_o), 64'hAAAA_BBBB);
    check("ms addr_o", 64'(addr_o), 64'h0010);
    rearm(16'h0010, 16'h00FF, 1'b0, 1'b0);
    push(16'h0001);
    wea = 1'b1; data = 16'h0002; flush = 1'b1;
    cycle();
    wea = 1'b0; flush = 1'b0;
    check("flush+emit wea_o", 64'(wea_o), 1);
    check("flush+emit data_o", 64'(data_o), 64'h0002_0001);
    cycle();
    check("flush+emit single write", 64'(wea_o), 0);
    check("flush+emit wcount", 64'(wcount_o), 1);
    restart2 = 1'b1;
    cycle();
    restart2 = 1'b0;
    push2(16'h0001);
    push2(16'h0002);
    push2(16'h0003);
    check("w64 no early write", 64'(wea_o2), 0);
    flush2 = 1'b1;
    cycle();
    check("w64 flush wea_o", 64'(wea_o2), 1);
    check("w64 flush data_o", data_o2, 64'h0000_0003_0002_0001);
    check("w64 flush addr_o", 64'(addr_o2), 0);
    cycle();
    flush2 = 1'b0;
    check("w64 second flush no write", 64'(wea_o2), 0);
    check("w64 wcount", 64'(wcount_o2), 1);
    rearm(16'h0005, 16'h0006, 1'b1, 1'b0);
    push(16'h0101); push(16'h0202);
    check("wrap addr 1", 64'(addr_o), 5);
    push(16'h0303); push(16'h0404);
    check("wrap addr 2", 64'(addr_o), 6);
    push(16'h0505); push(16'h0606);
    check("wrap addr 3", 64'(addr_o), 5);
    check("wrap not full", 64'(full_o), 0);
    check("wrap wcount", 64'(wcount_o), 3);
    rearm(16'h0005, 16'h0006, 1'b0, 1'b0);
    push(16'h0101); push(16'h0202);
    check("nowrap addr 1", 64'(addr_o), 5);
    check("nowrap not full yet", 64'(full_o), 0);
    push(16'h0303); push(16'h0404);
    check("nowrap addr 2", 64'(addr_o), 6);
    check("nowrap full", 64'(full_o), 1);
    check("nowrap no ovf yet", 64'(ovf_o), 0);
    push(16'h0505);
    check("dropped word sets ovf", 64'(ovf_o), 1);
    push(16'h0606);
    check("dropped pair no write", 64'(wea_o), 0);
    check("dropped pair data_o holds", 64'(data_o), 64'h0404_0303);
    check("dropped pair wcount", 64'(wcount_o), 2);
    rearm(16'h0005, 16'h0006, 1'b0, 1'b0);
    check("restart clears full/ovf", {62'd0, full_o, ovf_o}, 0);
    rearm(16'h0010, 16'h00FF, 1'b0, 1'b0);
    push(16'h1234);
    #2 rst_n_i = 1'b0;
    #1;
    check("async rst wea_o", 64'(wea_o), 0);
    check("async rst addr_o", 64'(addr_o), 0);
    cycle();
    check("in rst wea_o", 64'(wea_o), 0);
    rst_n_i = 1'b1;
    cycle();
    check("after rst wea_o", 64'(wea_o), 0);
    push(16'h5555);
    check("after rst partial lost", 64'(wea_o), 0);
    push(16'h6666);
    check("after rst wea_o", 64'(wea_o), 1);
    check("after rst data_o", 64'(data_o), 64'h6666_5555);
    check("after rst addr_o", 64'(addr_o), 0);
    check("after rst wcount", 64'(wcount_o), 1);
    check("after rst full at eaddr 0", 64'(full_o), 1);
    cycle();
    check("after rst single write", 64'(wea_o), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_pack.md
Name: pipe_pack

Overview:
- Parametrised successor to the 16→32 pipe-to-RAM packer.
- Accepts IN_W-bit host pipe words and packs RATIO = OUT_W/IN_W consecutive words into one OUT_W-bit RAM write.
- Auto-increments the RAM address from a programmable start to a programmable end, with optional wrap.
- Adds selectable lane order, partial-word flush, a write counter, and full/overflow status.
- Sits between the host pipe endpoint and a block-RAM write port.

Parameters:
- IN_W, 16, pipe word width.
- OUT_W, 32, RAM word width; OUT_W = RATIO*IN_W, with RATIO in {1,2,4,8}; any other value is an elaboration error.
- ADDR_W, 16, RAM address width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- restart_i  in  1  synchronous re-arm: loads the start/end addresses and clears lanes, counter and status.
- saddr_i  in  ADDR_W  start address, sampled on restart_i.
- eaddr_i  in  ADDR_W  last address, inclusive; sampled on restart_i.
- wrap_en_i  in  1  1 = wrap to start after eaddr; sampled on restart_i.
- msw_first_i  in  1  0 = first pipe word goes to the LS lane; 1 = first pipe word goes to the MS lane. Sampled on restart_i.
- wea_i  in  1  pipe word valid.
- data_i  in  IN_W  pipe word.
- flush_i  in  1  emit a partially filled word, zero-padded.
- data_o  out  OUT_W  RAM write data.
- addr_o  out  ADDR_W  RAM write address.
- wea_o  out  1  RAM write strobe, one cycle per word.
- wcount_o  out  ADDR_W+1  RAM words written since restart.
- full_o  out  1  eaddr written with wrap disabled; further input is dropped.
- ovf_o  out  1  sticky: a word arrived while full_o was set.

Behaviour:
- Reset (rst_n_i=0, asynchronous): all outputs are 0. Lane counter, assembly register, address pointer and the sampled mode bits are all cleared.
- restart_i (priority over everything else in the same cycle):
  - ptr ← saddr_i.
  - Latch eaddr_i, wrap_en_i and msw_first_i.
  - lane ← 0, assembly register ← 0.
  - data_o, addr_o, wea_o, wcount_o, full_o and ovf_o all ← 0.
  - Any partial word is discarded.
- Accept, when wea_i=1 and full_o=0:
  - data_i is stored in lane index `lane`, or RATIO-1-lane when msw_first.
  - lane increments.
- Emit, on the accept that fills lane RATIO-1:
  - Next cycle: wea_o=1, data_o = assembled word (including the current data_i), addr_o = ptr.
  - Same edge: lane ← 0, assembly register ← 0, wcount_o increments.
  - Latency is 1 clock from the last pipe word to wea_o.
  - RATIO=1 emits on every accept.
- wea_o is high for exactly one cycle per emitted word; otherwise 0. data_o and addr_o hold their last values.
- Address advance after each emit:
  - ptr≠eaddr: ptr+1, modulo 2^ADDR_W.
  - ptr=eaddr and wrap: ptr ← saddr.
  - ptr=eaddr and no wrap: full_o ← 1.
- Flush, when flush_i=1 with lane>0 (after the same-cycle accept, if any): emit as above with the unfilled lanes zero. If lane=0 after the accept, flush is a no-op. A flush coinciding with a natural emit produces one write, not two.
- Full: wea_i while full_o=1 sets ovf_o, and the word is discarded. Only restart_i or reset clears full_o and ovf_o.
- wea_i=0 with no flush: state holds; a partial word waits indefinitely.
- Reset asserted mid-word: the partial word is lost; no write is issued.
- saddr>eaddr is not checked: ptr increments and wraps modulo 2^ADDR_W until it equals eaddr.

Decomposition:
- Package pipe_pkg holds:
  - localparams for lane order (LANE_LS_FIRST=0, LANE_MS_FIRST=1);
  - a function lane_idx(lane, msw_first, RATIO);
  - a RATIO legality check macro, shared with the upcoming pipe_unpack.
- One natural sub-module: pipe_addr_gen, containing the start/end/wrap pointer, the full flag and the word counter. It is reusable by the read-side unpacker.
- Lane assembly and flush logic stay in pipe_pack.

Test Plan:
- Default params, saddr=0x0010, eaddr=0x00FF, LS-first; send 0x1111, 0x2222 → next cycle wea_o=1, data_o=0x2222_1111, addr_o=0x0010, wcount_o=1.
- msw_first=1; send 0xAAAA, 0xBBBB → data_o=0xAAAA_BBBB.
- OUT_W=64; send 3 words 0x0001..0x0003 then flush → data_o=0x0000_0003_0002_0001. A second flush produces no write.
- saddr=0x0005, eaddr=0x0006, wrap=1; 3 pairs → addr_o sequence 5, 6, 5.
- Same addresses, wrap=0; 3 pairs → writes at 5 and 6, full_o=1 after the 2nd write, 3rd pair dropped, ovf_o=1; restart_i clears both.
- Assert rst_n_i low after 1 of 2 words, then release and send 2 words → a single write of those 2 words at addr 0 (saddr not yet sampled). No spurious wea_o during or after reset.
